// File: rtl/mips_control_fsm_if.sv
// Control/status bundle between the multicycle MIPS controller and its datapath.
// The master side decodes IR fields and flags and drives strobes; the slave side is the datapath.
interface mips_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic [3:0]       alu_op;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic             imm_zext;
    logic             pc_write;
    logic [1:0]       pc_source;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             iord;
    logic             reg_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             illegal;
    logic [3:0]       state_dbg;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output alu_op, alu_src_a, alu_src_b, imm_zext, pc_write, pc_source,
               ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, illegal, state_dbg, instr_count
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  alu_op, alu_src_a, alu_src_b, imm_zext, pc_write, pc_source,
               ir_write, mem_read, mem_write, iord, reg_write, reg_dst,
               mem_to_reg, illegal, state_dbg, instr_count
    );
endinterface

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: registered state, strobes decoded combinationally from state/opcode/funct.
// Memory states stall on mem_ready; write strobes are masked while reset is high.
module mips_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    mips_control_fsm_if.master bus
);
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_LUI  = 4'b1011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             retire;

    logic             r_ok;
    logic [3:0]       r_op;
    logic [1:0]       r_src_a;
    logic [3:0]       i_op;

    logic [3:0]       alu_op;
    logic [1:0]       src_a, src_b, pc_source;
    logic             imm_zext, pc_write, ir_write, mem_read, mem_write;
    logic             iord, reg_write, reg_dst, mem_to_reg;

    // R-type funct decode; r_ok also decides R_EXEC vs TRAP at DECODE.
    always_comb begin
        r_ok    = 1'b1;
        r_op    = OP_ADD;
        r_src_a = 2'd1;
        case (bus.funct)
            6'h20, 6'h21: r_op = OP_ADD;
            6'h22, 6'h23: r_op = OP_SUB;
            6'h24:        r_op = OP_AND;
            6'h25:        r_op = OP_OR;
            6'h26:        r_op = OP_XOR;
            6'h27:        r_op = OP_NOR;
            6'h2A:        r_op = OP_SLT;
            6'h2B:        r_op = OP_SLTU;
            6'h00:        begin r_op = OP_SLL; r_src_a = 2'd2; end
            6'h02:        begin r_op = OP_SRL; r_src_a = 2'd2; end
            6'h03:        begin r_op = OP_SRA; r_src_a = 2'd2; end
            6'h04:        r_op = OP_SLL;
            6'h06:        r_op = OP_SRL;
            6'h07:        r_op = OP_SRA;
            default:      r_ok = 1'b0;
        endcase
    end

    always_comb begin
        i_op = OP_ADD;
        case (bus.opcode)
            6'h0A:   i_op = OP_SLT;
            6'h0B:   i_op = OP_SLTU;
            6'h0C:   i_op = OP_AND;
            6'h0D:   i_op = OP_OR;
            6'h0E:   i_op = OP_XOR;
            6'h0F:   i_op = OP_LUI;
            default: i_op = OP_ADD;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        alu_op     = OP_ADD;
        src_a      = 2'd0;
        src_b      = 2'd0;
        imm_zext   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'd0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = 2'd1;
                ir_write = bus.mem_ready;
                pc_write = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                src_b = 2'd3;
                case (bus.opcode)
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h00:        state_d = r_ok ? S_R_EXEC : S_TRAP;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    6'h08, 6'h09, 6'h0A, 6'h0B,
                    6'h0C, 6'h0D, 6'h0E, 6'h0F: state_d = S_I_EXEC;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                src_a   = 2'd1;
                src_b   = 2'd2;
                state_d = (bus.opcode == 6'h23) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                alu_op  = r_op;
                src_a   = r_src_a;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_op    = OP_SUB;
                src_a     = 2'd1;
                pc_source = 2'd1;
                pc_write  = (bus.opcode == 6'h04) ? bus.zero : ~bus.zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'd2;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_I_EXEC: begin
                alu_op   = i_op;
                src_a    = 2'd1;
                src_b    = 2'd2;
                imm_zext = (bus.opcode == 6'h0C) || (bus.opcode == 6'h0D) || (bus.opcode == 6'h0E);
                state_d  = S_I_WB;
            end
            S_I_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    assign illegal_d = illegal_q | (state_d == S_TRAP);
    assign cnt_d     = retire ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // State strobes are masked by reset itself so nothing commits while it is asserted.
    assign bus.pc_write    = pc_write  & ~reset;
    assign bus.ir_write    = ir_write  & ~reset;
    assign bus.mem_write   = mem_write & ~reset;
    assign bus.reg_write   = reg_write & ~reset;
    assign bus.alu_op      = alu_op;
    assign bus.alu_src_a   = src_a;
    assign bus.alu_src_b   = src_b;
    assign bus.imm_zext    = imm_zext;
    assign bus.pc_source   = pc_source;
    assign bus.mem_read    = mem_read;
    assign bus.iord        = iord;
    assign bus.reg_dst     = reg_dst;
    assign bus.mem_to_reg  = mem_to_reg;
    assign bus.illegal     = illegal_q;
    assign bus.state_dbg   = state_q;
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: directed test-plan sequence with literal expectations, then random
// instruction streams checked every cycle against an instruction-level reference model.
module tb_mips_control_fsm;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_control_fsm_if #(.CNT_W(CNT_W)) bus();
    mips_control_fsm #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic [3:0] alu_op;
        logic [1:0] sa;
        logic [1:0] sb;
        logic       zx;
        logic       pw;
        logic [1:0] ps;
        logic       irw;
        logic       mr;
        logic       mw;
        logic       iord;
        logic       rw;
        logic       rd;
        logic       m2r;
    } outv_t;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: each instruction is a list of post-DECODE steps; leaving the last step retires.
    int               m_st;
    logic [CNT_W-1:0] m_cnt;
    bit               m_ill;
    int               seq[$];
    int               idx;

    int         i_tab[8] = '{0, 0, 6, 7, 2, 3, 4, 11};
    logic [5:0] fn_tab[16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                               6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_st  = 0;
        m_cnt = '0;
        m_ill = 1'b0;
        seq.delete();
        idx   = 0;
    endtask

    function automatic void r_info(input logic [5:0] f, output bit ok, output int op, output int sa);
        ok = 1'b1;
        op = 0;
        sa = 1;
        case (f)
            6'h20, 6'h21: op = 0;
            6'h22, 6'h23: op = 1;
            6'h24: op = 2;
            6'h25: op = 3;
            6'h26: op = 4;
            6'h27: op = 5;
            6'h2A: op = 6;
            6'h2B: op = 7;
            6'h00: begin op = 8;  sa = 2; end
            6'h02: begin op = 9;  sa = 2; end
            6'h03: begin op = 10; sa = 2; end
            6'h04: op = 8;
            6'h06: op = 9;
            6'h07: op = 10;
            default: ok = 1'b0;
        endcase
    endfunction

    task automatic build_seq();
        bit ok;
        int op, sa;
        int opc;
        opc = int'(bus.opcode);
        r_info(bus.funct, ok, op, sa);
        if (opc == 'h23)                 seq = '{2, 3, 4};
        else if (opc == 'h2B)            seq = '{2, 5};
        else if (opc == 0 && ok)         seq = '{6, 7};
        else if (opc == 4 || opc == 5)   seq = '{8};
        else if (opc == 2)               seq = '{9};
        else if (opc >= 8 && opc <= 15)  seq = '{10, 11};
        else                             seq = '{12};
    endtask

    task automatic model_update();
        if (reset) begin
            m_reset();
        end else if (m_st == 0) begin
            if (bus.mem_ready) m_st = 1;
        end else if (m_st == 1) begin
            build_seq();
            idx  = 0;
            m_st = seq[0];
            if (m_st == 12) m_ill = 1'b1;
        end else if (m_st == 12) begin
            m_st = 12;
        end else if ((m_st == 3 || m_st == 5) && !bus.mem_ready) begin
            m_st = m_st;
        end else begin
            idx++;
            if (idx == seq.size()) begin
                m_cnt = m_cnt + 1'b1;
                m_st  = 0;
            end else begin
                m_st = seq[idx];
            end
        end
    endtask

    function automatic outv_t expect_out();
        outv_t o;
        bit ok;
        int op, sa;
        o = '0;
        case (m_st)
            0:  begin o.mr = 1; o.sb = 1; o.irw = bus.mem_ready; o.pw = bus.mem_ready; end
            1:  o.sb = 3;
            2:  begin o.sa = 1; o.sb = 2; end
            3:  begin o.mr = 1; o.iord = 1; end
            4:  begin o.rw = 1; o.m2r = 1; end
            5:  begin o.mw = 1; o.iord = 1; end
            6:  begin r_info(bus.funct, ok, op, sa); o.alu_op = 4'(op); o.sa = 2'(sa); end
            7:  begin o.rw = 1; o.rd = 1; end
            8:  begin
                    o.alu_op = 1; o.sa = 1; o.ps = 1;
                    o.pw = (bus.opcode == 6'h04) ? bus.zero : !bus.zero;
                end
            9:  begin o.pw = 1; o.ps = 2; end
            10: begin
                    o.alu_op = 4'(i_tab[int'(bus.opcode) - 8]);
                    o.sa = 1; o.sb = 2;
                    o.zx = (bus.opcode >= 6'h0C && bus.opcode <= 6'h0E);
                end
            11: o.rw = 1;
            default: ;
        endcase
        if (reset) begin
            o.pw = 0; o.irw = 0; o.mw = 0; o.rw = 0;
        end
        return o;
    endfunction

    task automatic settle();
        outv_t e, a;
        #1;
        e = expect_out();
        a = {bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.imm_zext, bus.pc_write, bus.pc_source,
             bus.ir_write, bus.mem_read, bus.mem_write, bus.iord, bus.reg_write, bus.reg_dst,
             bus.mem_to_reg};
        chk("model_outputs", 32'(a), 32'(e));
        chk("model_state", 32'(bus.state_dbg), 32'(m_st));
        chk("model_illegal", 32'(bus.illegal), 32'(m_ill));
        chk("model_count", 32'(bus.instr_count), 32'(m_cnt));
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Drives one fetch with mem_ready=1 and leaves the FSM in the first post-DECODE state.
    task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input int exp_cnt);
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = 1'b1;
        settle();
        chk("fetch_count", 32'(bus.instr_count), 32'(exp_cnt));
        chk("fetch_ir_write", 32'(bus.ir_write), 32'd1);
        chk("fetch_pc_write", 32'(bus.pc_write), 32'd1);
        adv();
        settle();
        chk("decode_state", 32'(bus.state_dbg), 32'd1);
        adv();
    endtask

    initial begin
        int trap_cyc;
        int r;
        reset         = 1'b1;
        bus.opcode    = 6'h00;
        bus.funct     = 6'h20;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        m_reset();
        adv();

        bus.mem_ready = 1'b1;
        settle();
        chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
        chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
        chk("rst_state", 32'(bus.state_dbg), 32'd0);
        chk("rst_count", 32'(bus.instr_count), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        adv();

        reset         = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (3) begin
            settle();
            chk("wait_state", 32'(bus.state_dbg), 32'd0);
            chk("wait_ir_write", 32'(bus.ir_write), 32'd0);
            chk("wait_mem_read", 32'(bus.mem_read), 32'd1);
            adv();
        end

        do_fetch(6'h00, 6'h03, 0);
        settle();
        chk("sra_alu_op", 32'(bus.alu_op), 32'b1010);
        chk("sra_src_a", 32'(bus.alu_src_a), 32'd2);
        adv();
        settle();
        chk("rwb_reg_write", 32'(bus.reg_write), 32'd1);
        chk("rwb_reg_dst", 32'(bus.reg_dst), 32'd1);
        adv();

        do_fetch(6'h0D, 6'h00, 1);
        settle();
        chk("ori_alu_op", 32'(bus.alu_op), 32'b0011);
        chk("ori_zext", 32'(bus.imm_zext), 32'd1);
        chk("ori_src_b", 32'(bus.alu_src_b), 32'd2);
        adv(); settle(); adv();

        do_fetch(6'h0F, 6'h00, 2);
        settle();
        chk("lui_alu_op", 32'(bus.alu_op), 32'b1011);
        chk("lui_zext", 32'(bus.imm_zext), 32'd0);
        adv(); settle(); adv();

        bus.zero = 1'b1;
        do_fetch(6'h04, 6'h00, 3);
        settle();
        chk("beq_taken_pc_write", 32'(bus.pc_write), 32'd1);
        chk("beq_pc_source", 32'(bus.pc_source), 32'd1);
        adv();
        bus.zero = 1'b0;
        do_fetch(6'h04, 6'h00, 4);
        settle();
        chk("beq_nt_pc_write", 32'(bus.pc_write), 32'd0);
        adv();
        do_fetch(6'h05, 6'h00, 5);
        settle();
        chk("bne_taken_pc_write", 32'(bus.pc_write), 32'd1);
        adv();

        do_fetch(6'h2B, 6'h00, 6);
        settle(); adv();
        bus.mem_ready = 1'b0;
        repeat (2) begin
            settle();
            chk("sw_wait_mem_write", 32'(bus.mem_write), 32'd1);
            adv();
        end
        bus.mem_ready = 1'b1;
        settle();
        chk("sw_done_mem_write", 32'(bus.mem_write), 32'd1);
        adv();

        do_fetch(6'h23, 6'h00, 7);
        settle(); adv();
        settle(); adv();
        settle();
        chk("lw_mem_to_reg", 32'(bus.mem_to_reg), 32'd1);
        chk("lw_reg_write", 32'(bus.reg_write), 32'd1);
        adv();

        do_fetch(6'h2B, 6'h00, 8);
        settle(); adv();
        bus.mem_ready = 1'b0;
        settle();
        chk("sw2_mem_write", 32'(bus.mem_write), 32'd1);
        reset = 1'b1;
        m_reset();
        settle();
        chk("abort_mem_write", 32'(bus.mem_write), 32'd0);
        chk("abort_state", 32'(bus.state_dbg), 32'd0);
        chk("abort_count", 32'(bus.instr_count), 32'd0);
        adv();
        reset = 1'b0;

        do_fetch(6'h3F, 6'h00, 0);
        bus.mem_ready = 1'b1;
        repeat (10) begin
            settle();
            chk("trap_illegal", 32'(bus.illegal), 32'd1);
            chk("trap_state", 32'(bus.state_dbg), 32'd12);
            chk("trap_strobes", 32'({bus.pc_write, bus.ir_write, bus.mem_read,
                                      bus.mem_write, bus.reg_write}), 32'd0);
            adv();
        end
        reset = 1'b1;
        m_reset();
        settle();
        adv();
        reset = 1'b0;

        trap_cyc = 0;
        for (int c = 0; c < 4000; c++) begin
            if (m_st == 12) trap_cyc++;
            if ((trap_cyc > 3 && $urandom_range(0, 2) == 0) || $urandom_range(0, 299) == 0) begin
                reset    = 1'b1;
                trap_cyc = 0;
                m_reset();
            end else begin
                reset = 1'b0;
            end
            if (m_st == 0) begin
                r = int'($urandom_range(0, 19));
                bus.funct = fn_tab[$urandom_range(0, 15)];
                if (r <= 3)       bus.opcode = 6'h00;
                else if (r <= 5)  bus.opcode = 6'h23;
                else if (r <= 7)  bus.opcode = 6'h2B;
                else if (r <= 9)  bus.opcode = 6'h04;
                else if (r == 10) bus.opcode = 6'h05;
                else if (r == 11) bus.opcode = 6'h02;
                else if (r <= 17) bus.opcode = 6'(8 + $urandom_range(0, 7));
                else              bus.opcode = 6'($urandom_range(0, 63));
                if (r == 3) bus.funct = 6'($urandom_range(0, 63));
            end
            bus.zero      = 1'($urandom_range(0, 1));
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            settle();
            adv();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mips_control_fsm.md
Name: mips_control_fsm

Overview:
- Multicycle control unit for the MIPS datapath. It is the producer side of the ALU's `op` / `zero` interface.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Decodes `opcode`/`funct` into the ALU's 4-bit operation code and drives all datapath strobes (PC, IR, memory, register file).
- Consumes the ALU `zero` flag for branches, handles a memory-ready handshake, and counts retired instructions.

Parameters:
- `CNT_W`, 32, width of the retired-instruction counter.

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `opcode`  input  6  IR[31:26]; held stable by datapath after the IR write.
- `funct`  input  6  IR[5:0].
- `zero`  input  1  ALU zero flag.
- `mem_ready`  input  1  memory access completes this cycle.
- `alu_op`  output  4  ADD=0000 SUB=0001 AND=0010 OR=0011 XOR=0100 NOR=0101 SLT=0110 SLTU=0111 SLL=1000 SRL=1001 SRA=1010 LUI=1011.
- `alu_src_a`  output  2  0=PC, 1=reg[rs], 2=shamt (zero-extended).
- `alu_src_b`  output  2  0=reg[rt], 1=const 4, 2=extended imm, 3=extended imm<<2.
- `imm_zext`  output  1  1=zero-extend imm, 0=sign-extend.
- `pc_write`  output  1  PC load.
- `pc_source`  output  2  0=ALU result, 1=ALUOut register, 2=jump target.
- `ir_write`  output  1  IR load.
- `mem_read`  output  1  memory read request.
- `mem_write`  output  1  memory write request.
- `iord`  output  1  memory address: 0=PC, 1=ALUOut.
- `reg_write`  output  1  register file write.
- `reg_dst`  output  1  1=rd, 0=rt.
- `mem_to_reg`  output  1  1=MDR, 0=ALUOut.
- `illegal`  output  1  sticky: undefined instruction trapped.
- `state_dbg`  output  4  current state encoding.
- `instr_count`  output  CNT_W  retired instructions.

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, TRAP=12.
- State is registered. Outputs are decoded combinationally from state, `opcode` and `funct`. Any strobe not listed for a state is 0. Default `alu_op` is ADD.

Reset:
- `reset` high sets state=FETCH, `illegal`=0, `instr_count`=0, asynchronously.
- While `reset` is high, `pc_write`, `ir_write`, `mem_write` and `reg_write` are forced to 0.

State by state:
- FETCH: `mem_read`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=1, ADD, `pc_source`=0.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stay in FETCH while `mem_ready`=0; go to DECODE when it is 1.
- DECODE: ADD, `alu_src_a`=0, `alu_src_b`=3, sign-extend (branch target into ALUOut). Next state:
  - `opcode` 0x23/0x2B -> MEM_ADDR.
  - `opcode` 0x00 with valid funct -> R_EXEC.
  - `opcode` 0x04/0x05 -> BRANCH.
  - `opcode` 0x02 -> JUMP.
  - `opcode` 0x08-0x0F -> I_EXEC.
  - Anything else -> TRAP.
- R_EXEC: `alu_src_b`=0. ALU op by funct:
  - 0x20/0x21 ADD, 0x22/0x23 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR, 0x2A SLT, 0x2B SLTU; `alu_src_a`=1 for all of these.
  - Shifts with `alu_src_a`=2: 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - Variable shifts with `alu_src_a`=1: 0x04 SLL, 0x06 SRL, 0x07 SRA.
  - Any other funct is treated as illegal at DECODE.
  - Next state R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. Retire, then FETCH.
- I_EXEC: `alu_src_a`=1, `alu_src_b`=2. ALU op by opcode:
  - 0x08/0x09 ADD, 0x0A SLT, 0x0B SLTU, 0x0C AND, 0x0D OR, 0x0E XOR, 0x0F LUI.
  - `imm_zext`=1 for 0x0C-0x0E only.
  - Next state I_WB.
- I_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. Retire, then FETCH.
- MEM_ADDR: ADD, `alu_src_a`=1, `alu_src_b`=2. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: `mem_read`=1, `iord`=1. Wait while `!mem_ready`, then MEM_WB.
- MEM_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1. Retire, then FETCH.
- MEM_WR: `mem_write`=1, `iord`=1. Hold while `!mem_ready`. When `mem_ready`=1, retire, then FETCH.
- BRANCH: SUB, `alu_src_a`=1, `alu_src_b`=0, `pc_source`=1.
  - `pc_write` = (beq & `zero`) | (bne & !`zero`).
  - Retire (taken or not), then FETCH.
- JUMP: `pc_write`=1, `pc_source`=2. Retire, then FETCH.
- TRAP: `illegal`=1. Terminal: no strobes, no retire, no exit except reset.

Counter and boundaries:
- "Retire" means `instr_count` += 1 on that clock edge. The counter wraps from all-ones to 0.
- Reset mid-wait (e.g. MEM_WR with `mem_ready`=0) aborts immediately. No write strobe is observed after `reset` rises.
- `mem_ready` asserted in a state that does not request memory is ignored.

Test Plan:
- Reset, then hold `mem_ready`=0 for 3 cycles -> state_dbg stays 0, `ir_write`=0, `pc_write`=0, `mem_read`=1. Raise `mem_ready` -> one `ir_write`/`pc_write` pulse, state 1.
- R-type `opcode`=0, `funct`=0x03 (sra) -> R_EXEC shows `alu_op`=1010 with `alu_src_a`=2; then R_WB `reg_write`=1, `reg_dst`=1; `instr_count` 0->1; total 4 cycles with `mem_ready` tied 1.
- ori (`opcode`=0x0D) -> `alu_op`=0011, `imm_zext`=1, `alu_src_b`=2. lui (0x0F) -> `alu_op`=1011, `imm_zext`=0.
- beq with `zero`=1 -> `pc_write`=1, `pc_source`=1. beq with `zero`=0 -> `pc_write`=0. bne with `zero`=0 -> `pc_write`=1. `instr_count` increments all three times.
- sw with `mem_ready`=0 for 2 cycles in MEM_WR -> `mem_write` held 3 cycles, one retire. Then lw -> `mem_to_reg`=1 in MEM_WB.
- `opcode`=0x3F -> TRAP, `illegal`=1 persists 10 cycles with no strobes. Assert `reset` mid-MEM_WR -> `mem_write`=0 immediately, state 0, `instr_count`=0.
